// File: rtl/ulpi_phy_emu.sv
// ulpi_phy_emu: PHY-side ULPI responder answering reset, register access and RX CMD on line-state change.
// Outputs are flopped from the next-state decode so they change on the edge that enters each state.
module ulpi_phy_emu #(
    parameter int          STARTUP_CYCLES = 16,
    parameter logic [15:0] VID            = 16'h0424,
    parameter logic [15:0] PID            = 16'h0009
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_phy_rst,
    input  logic       i_stp,
    input  logic [7:0] i_data,
    output logic       o_dir,
    output logic       o_nxt,
    output logic [7:0] o_data,
    input  logic [1:0] i_linestate,
    output logic [7:0] o_func_ctrl
);
    typedef enum logic [3:0] {
        RESET, STARTUP, IDLE, REGW_CMD, REGW_DATA, REGR_CMD,
        REGR_TA, REGR_DATA, REGR_END, RX_TA, RX_DATA, RX_END
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [5:0]  r_addr, w_base, w_off;
    logic [7:0]  r_wdata, w_wval, w_data, r_data;
    logic [7:0]  r_regs [64];
    logic [1:0]  r_ls, r_last;
    logic        r_pend, r_dir, r_nxt, w_dir, w_nxt, w_grp, w_wen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RESET;
            r_dir   <= 1'b1;
            r_nxt   <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            r_dir   <= w_dir;
            r_nxt   <= w_nxt;
            r_data  <= w_data;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET:     w_next = STARTUP;
            STARTUP:   w_next = (r_cnt == '0) ? IDLE : STARTUP;
            IDLE:      w_next = (i_data[7:6] == 2'b10) ? REGW_CMD :
                                (i_data[7:6] == 2'b11) ? REGR_CMD :
                                r_pend ? RX_TA : IDLE;
            REGW_CMD:  w_next = i_stp ? IDLE : REGW_DATA;
            REGW_DATA: w_next = i_stp ? IDLE : REGW_DATA;
            REGR_CMD:  w_next = i_stp ? IDLE : REGR_TA;
            REGR_TA:   w_next = REGR_DATA;
            REGR_DATA: w_next = REGR_END;
            REGR_END:  w_next = IDLE;
            RX_TA:     w_next = i_stp ? IDLE : RX_DATA;
            RX_DATA:   w_next = RX_END;
            RX_END:    w_next = IDLE;
            default:   w_next = RESET;
        endcase
        if (i_phy_rst) w_next = RESET;
    end

    always_comb begin
        w_dir  = w_next inside {RESET, STARTUP, REGR_TA, REGR_DATA, RX_TA, RX_DATA};
        w_nxt  = w_next inside {REGW_CMD, REGR_CMD};
        w_data = (w_next == REGR_DATA) ? r_regs[w_base] :
                 (w_next == RX_DATA) ? {6'b0, i_linestate} : 8'h00;
    end

    // Counter reloads whenever not counting, so entry into STARTUP always sees a full count.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != STARTUP) r_cnt <= 16'(STARTUP_CYCLES - 1);
        else r_cnt <= r_cnt - 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && i_data[7]) r_addr <= i_data[5:0];
        if (r_state == REGW_DATA && !i_stp) r_wdata <= i_data;
        if (r_state == RX_TA) r_ls <= i_linestate;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 2'b00;
            r_pend <= 1'b0;
        end else if (r_state == RX_DATA && w_next == RX_END) begin
            r_last <= r_ls;
            r_pend <= 1'b0;
        end else if (i_linestate != r_last) begin
            r_pend <= 1'b1;
        end
    end

    // Addresses 0x04..0x15 form write/set/clear triplets that all resolve to the group base.
    always_comb begin
        w_grp  = r_addr >= 6'h04 && r_addr < 6'h16;
        w_base = r_addr;
        if (w_grp)
            for (int k = 0; k < 6; k++)
                if (r_addr >= 6'(4 + 3 * k)) w_base = 6'(4 + 3 * k);
        w_off  = r_addr - w_base;
        w_wval = (w_off == 6'd1) ? (r_regs[w_base] | r_wdata) :
                 (w_off == 6'd2) ? (r_regs[w_base] & ~r_wdata) : r_wdata;
        w_wen  = r_state == REGW_DATA && i_stp && !i_phy_rst && r_addr >= 6'h04;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_phy_rst) begin
            for (int i = 0; i < 64; i++) r_regs[i] <= 8'h00;
            r_regs[0] <= VID[7:0];
            r_regs[1] <= VID[15:8];
            r_regs[2] <= PID[7:0];
            r_regs[3] <= PID[15:8];
            r_regs[4] <= 8'h41;
        end else if (w_wen) begin
            r_regs[w_base] <= w_wval;
        end
    end

    assign o_dir       = r_dir;
    assign o_nxt       = r_nxt;
    assign o_data      = r_data;
    assign o_func_ctrl = r_regs[4];
endmodule

// File: tb/tb_ulpi_phy_emu.sv
// tb_ulpi_phy_emu: vector table of register accesses plus hand sequences for reset, RX CMD and aborts.
// A negedge monitor recognises two-cycle PHY-driven frames and checks them against a scoreboard queue.
module tb_ulpi_phy_emu;
    logic       i_clk = 1'b0;
    logic       i_rst, i_phy_rst, i_stp;
    logic [7:0] i_data;
    logic [1:0] i_linestate;
    logic       o_dir, o_nxt;
    logic [7:0] o_data, o_func_ctrl;

    int         checks = 0;
    int         errors = 0;
    int         mon_cnt = 0;
    logic [7:0] mon_ta, mon_db, sb_exp;
    logic [7:0] sb [$];

    typedef struct {
        bit         wr;
        logic [5:0] addr;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vt [$];

    ulpi_phy_emu dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_phy_rst(i_phy_rst), .i_stp(i_stp),
        .i_data(i_data), .o_dir(o_dir), .o_nxt(o_nxt), .o_data(o_data),
        .i_linestate(i_linestate), .o_func_ctrl(o_func_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        if (o_dir) begin
            mon_cnt++;
            if (mon_cnt == 1) mon_ta = o_data;
            if (mon_cnt == 2) mon_db = o_data;
        end else begin
            if (mon_cnt == 2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %h expected none", mon_db);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("frame", {mon_ta, mon_db}, {8'h00, sb_exp});
                end
            end
            mon_cnt = 0;
        end
    end

    task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input logic [7:0] fc, input string nm);
        i_data = {2'b10, a};
        tick();
        chk({nm, "_nxt"}, 16'(o_nxt), 16'd1);
        i_data = d;
        tick();
        tick();
        i_data = 8'h00;
        i_stp  = 1'b1;
        tick();
        i_stp  = 1'b0;
        chk({nm, "_fc"}, 16'(o_func_ctrl), 16'(fc));
    endtask

    task automatic reg_read(input logic [5:0] a, input logic [7:0] e, input string nm);
        sb.push_back(e);
        i_data = {2'b11, a};
        tick();
        chk({nm, "_nxt"}, 16'(o_nxt), 16'd1);
        i_data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic startup_check(input string nm);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("%s_dir%0d", nm, i), 16'(o_dir), (i < 16) ? 16'd1 : 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back('{1'b0, 6'h00, 8'h00, 8'h24});
        vt.push_back('{1'b0, 6'h01, 8'h00, 8'h04});
        vt.push_back('{1'b0, 6'h02, 8'h00, 8'h09});
        vt.push_back('{1'b0, 6'h03, 8'h00, 8'h00});
        vt.push_back('{1'b0, 6'h04, 8'h00, 8'h41});
        vt.push_back('{1'b1, 6'h04, 8'h00, 8'h00});
        vt.push_back('{1'b1, 6'h05, 8'h03, 8'h03});
        vt.push_back('{1'b1, 6'h06, 8'h01, 8'h02});
        vt.push_back('{1'b0, 6'h05, 8'h00, 8'h02});
        vt.push_back('{1'b0, 6'h06, 8'h00, 8'h02});
        vt.push_back('{1'b1, 6'h00, 8'h55, 8'h02});
        vt.push_back('{1'b0, 6'h00, 8'h00, 8'h24});
        vt.push_back('{1'b1, 6'h01, 8'hFF, 8'h02});
        vt.push_back('{1'b0, 6'h01, 8'h00, 8'h04});
        vt.push_back('{1'b1, 6'h07, 8'hA5, 8'h02});
        vt.push_back('{1'b1, 6'h09, 8'h05, 8'h02});
        vt.push_back('{1'b0, 6'h08, 8'h00, 8'hA0});
        vt.push_back('{1'b1, 6'h13, 8'hF0, 8'h02});
        vt.push_back('{1'b1, 6'h14, 8'h0F, 8'h02});
        vt.push_back('{1'b0, 6'h15, 8'h00, 8'hFF});
        vt.push_back('{1'b1, 6'h15, 8'h3C, 8'h02});
        vt.push_back('{1'b0, 6'h13, 8'h00, 8'hC3});
        vt.push_back('{1'b0, 6'h16, 8'h00, 8'h00});
        vt.push_back('{1'b1, 6'h16, 8'h33, 8'h02});
        vt.push_back('{1'b0, 6'h16, 8'h00, 8'h33});
        vt.push_back('{1'b1, 6'h3F, 8'h5A, 8'h02});
        vt.push_back('{1'b0, 6'h3F, 8'h00, 8'h5A});
        vt.push_back('{1'b1, 6'h05, 8'h40, 8'h42});

        i_rst = 1'b1;
        i_phy_rst = 1'b1;
        i_stp = 1'b0;
        i_data = 8'h00;
        i_linestate = 2'b00;
        repeat (2) tick();
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst_out%0d", i), 16'({o_dir, o_nxt, o_data}), 16'h200);
        end
        chk("rst_fc", 16'(o_func_ctrl), 16'h41);
        i_phy_rst = 1'b0;
        startup_check("startup");
        chk("startup_out", 16'({o_nxt, o_data}), 16'h000);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) reg_write(vt[i].addr, vt[i].d, vt[i].exp, $sformatf("vec%0d", i));
            else reg_read(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Line-state change seen in IDLE: RX CMD starts one cycle after pending is raised.
        i_linestate = 2'b01;
        sb.push_back(8'h01);
        tick();
        chk("rx_wait_dir", 16'(o_dir), 16'd0);
        tick();
        chk("rx_start_dir", 16'(o_dir), 16'd1);
        repeat (3) tick();

        // Change arriving with a read is reported only after the read completes.
        i_linestate = 2'b10;
        reg_read(6'h00, 8'h24, "rd_ls");
        chk("rx_defer_dir", 16'(o_dir), 16'd0);
        sb.push_back(8'h02);
        tick();
        chk("rx_after_rd_dir", 16'(o_dir), 16'd1);
        repeat (3) tick();

        // PHY reset in REGR_DATA aborts the read and restores defaults.
        i_data = {2'b11, 6'h04};
        tick();
        i_data = 8'h00;
        tick();
        tick();
        i_phy_rst = 1'b1;
        tick();
        chk("abort_out", 16'({o_dir, o_nxt, o_data}), 16'h200);
        chk("abort_fc", 16'(o_func_ctrl), 16'h41);
        i_phy_rst = 1'b0;
        startup_check("restart");

        // Stop during REGW_CMD: no write and straight back to IDLE.
        i_data = {2'b10, 6'h04};
        tick();
        i_data = 8'h77;
        i_stp = 1'b1;
        tick();
        i_stp = 1'b0;
        i_data = 8'h00;
        chk("stp_cmd_out", 16'({o_dir, o_nxt}), 16'h0);
        tick();
        chk("stp_cmd_fc", 16'(o_func_ctrl), 16'h41);
        reg_read(6'h04, 8'h41, "stp_cmd_rd");

        repeat (3) tick();
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ulpi_phy_emu.md
# ulpi_phy_emu

PHY-side ULPI responder: the far end of the link-side ULPI controller, used to emulate a USB PHY in simulation and FPGA prototyping. It drives `dir`/`nxt`/`data` toward the link and answers the link's reset handshake. It emits RX CMD bytes on line-state changes and executes link register writes and reads against an internal 64×8 register file.

## Interface
Parameters:
- STARTUP_CYCLES, 16, cycles `dir` stays high after `i_phy_rst` falls (≥1)
- VID, 16'h0424, vendor ID, read-only at 0x00 (lo) / 0x01 (hi)
- PID, 16'h0009, product ID, read-only at 0x02 (lo) / 0x03 (hi)

Ports:
- i_clk  in  1  ULPI 60 MHz clock; every signal sampled/driven on its rising edge
- i_rst  in  1  synchronous, active-high emulator reset
- i_phy_rst  in  1  ULPI reset from link, active-high
- i_stp  in  1  link stop
- i_data  in  8  link-driven data bus
- o_dir  out  1  bus direction (1 = PHY drives)
- o_nxt  out  1  PHY throttle
- o_data  out  8  PHY-driven data bus; 8'h00 whenever o_dir=0 or in turnaround
- i_linestate  in  2  emulated USB line state
- o_func_ctrl  out  8  live value of register 0x04, for observation

## Operation
- All outputs registered. Reset (i_rst=1) values: state RESET, o_dir=1, o_nxt=0, o_data=0, register file at defaults, last-reported linestate=2'b00, rx_pending=0.
- Register defaults: 0x04=8'h41, 0x07..0x3F=0, 0x00..0x03 from VID/PID.
- States and transitions:
  - RESET: o_dir=1. When i_phy_rst=0, go to STARTUP and load counter with STARTUP_CYCLES-1.
  - STARTUP: o_dir=1. Decrement the counter. At 0, go to IDLE with o_dir=0.
  - IDLE: o_dir=0, o_nxt=0.
    - If i_data[7:6]=2'b10, latch addr=i_data[5:0] and go to REGW_CMD.
    - Else if i_data[7:6]=2'b11, latch addr and go to REGR_CMD.
    - Else if rx_pending, go to RX_TA.
    - Other i_data values are ignored.
  - REGW_CMD: o_nxt=1 for one cycle, then REGW_DATA.
  - REGW_DATA: o_nxt=0. While i_stp=0, latch i_data as wdata. On i_stp=1, commit the write using the last wdata latched, then go to IDLE.
  - REGR_CMD: o_nxt=1 for one cycle, then REGR_TA.
  - REGR_TA: o_dir=1, o_data=0 (turnaround), then REGR_DATA.
  - REGR_DATA: o_dir=1, o_data=reg[addr], then REGR_END.
  - REGR_END: o_dir=0 (turnaround), then IDLE.
  - RX_TA: o_dir=1, o_data=0. Snapshot ls=i_linestate.
  - RX_DATA: o_data={6'b0, ls}. Set last-reported to ls, clear rx_pending, then RX_END.
  - RX_END: o_dir=0, then IDLE.
- rx_pending is set in any cycle where i_linestate ≠ last-reported, regardless of state. A change arriving during an RX CMD or register access is reported after returning to IDLE.
- Write decode:
  - 0x00..0x03: write ignored.
  - 0x04..0x15: group base B=4+3·k. A=B writes the value, A=B+1 sets bits (reg|=d), A=B+2 clears bits (reg&=~d). Reads of A, B+1 or B+2 all return reg[B].
  - 0x16..0x3F: plain read/write.
- Boundaries:
  - i_phy_rst=1 in any state: go to RESET next cycle, o_dir=1, o_nxt=0, registers to defaults, pending accesses aborted.
  - i_stp=1 in REGW_CMD, REGR_CMD or RX_TA: abort without a write and go to IDLE with o_dir=0.
  - i_stp is ignored in RESET and STARTUP.
  - A TX CMD in IDLE takes priority over rx_pending.

## Timing
- Reset exit: o_dir falls STARTUP_CYCLES+1 cycles after the first cycle where i_phy_rst=0 is sampled.
- Register write: TX CMD sampled at edge T → o_nxt=1 in cycle T+1 → data bytes from T+2 onward → stp sampled at edge S → register updated and visible on o_func_ctrl at S+1.
- Register read: TX CMD at T → o_nxt=1 at T+1, o_dir=1 at T+2 (turnaround), data at T+3, o_dir=0 at T+4, IDLE at T+5.
- RX CMD: 3 cycles with o_dir high-turnaround-low. The earliest start is 1 cycle after rx_pending is set while in IDLE.

## Test plan
- Reset: i_phy_rst=1 for 5 cycles then 0 → o_dir=1 throughout, o_dir=0 exactly 17 cycles after release (STARTUP_CYCLES=16), o_nxt=0, o_data=0.
- Read ID: TX CMD 8'hC0, then 8'hC1 → o_nxt pulse at T+1, o_data=8'h24 then 8'h04 at T+3, o_dir low at T+4.
- Write/set/clear: write 8'h84+d 8'h00, then 8'h85 with 8'h03, then 8'h86 with 8'h01 → o_func_ctrl = 8'h00, then 8'h03, then 8'h02. A write to 8'h80 leaves the VID readback unchanged.
- Line state: i_linestate 00→01 in IDLE → o_dir=1, o_data 8'h00 then 8'h01, then o_dir=0. A change during a register read is delayed until after REGR_END.
- Abort: i_phy_rst=1 in REGR_DATA → o_dir=1 next cycle and o_func_ctrl=8'h41. Separately, stp in REGW_CMD → no write and IDLE on the next cycle.
